vending_controller: RTL and testbench

VENDING_CONTROLLER -- requirements
Module: vending_controller

---
 rtl/vending_if.sv | 33 +++
 rtl/vending_controller.sv | 151 +++++++++++++++
 tb/tb_vending_controller.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/vending_if.sv
// Coin, selection and dispenser signals of the vending controller, grouped as one bundle.
// The master side (machine front panel / dispenser) drives requests; the slave side is the controller.
interface vending_if;
  logic [1:0] x;
  logic [1:0] sel;
  logic       sel_valid;
  logic       cancel;
  logic       restock;
  logic       disp_ack;
  logic       disp_req;
  logic [1:0] disp_item;
  logic       change_pulse;
  logic       coin_reject;
  logic       sel_reject;
  logic       fault;
  logic [5:0] credit;
  logic [3:0] sold_out;
  logic [1:0] state_dbg;

  // disp_req/disp_ack: disp_req rises with disp_item valid and both hold steady until
  // the cycle after disp_ack=1 is sampled (or the timeout fires); ack outside a request is ignored.
  modport master (
    output x, sel, sel_valid, cancel, restock, disp_ack,
    input  disp_req, disp_item, change_pulse, coin_reject, sel_reject, fault,
           credit, sold_out, state_dbg
  );

  modport slave (
    input  x, sel, sel_valid, cancel, restock, disp_ack,
    output disp_req, disp_item, change_pulse, coin_reject, sel_reject, fault,
           credit, sold_out, state_dbg
  );
endinterface

// File: rtl/vending_controller.sv
// Four-item vending controller: collects 5/10 coins, sells one item per request,
// waits for the dispenser with a timeout and pays change back one 5-unit coin per cycle.
module vending_controller #(
  parameter int PRICE0       = 15,
  parameter int PRICE1       = 20,
  parameter int PRICE2       = 25,
  parameter int PRICE3       = 10,
  parameter int STOCK_INIT   = 3,
  parameter int MAX_CREDIT   = 30,
  parameter int DISP_TIMEOUT = 8
) (
  input logic      clk,
  input logic      rst,
  vending_if.slave bus
);

  typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE, CHANGE} state_t;

  localparam logic [2:0] STOCK_L = 3'(STOCK_INIT);
  localparam logic [6:0] MAX_L   = 7'(MAX_CREDIT);
  localparam logic [7:0] TO_LAST = 8'(DISP_TIMEOUT - 1);

  state_t     state;
  logic [2:0] stock [4];
  logic [7:0] timer;
  logic [5:0] credit;
  logic [1:0] disp_item;
  logic       disp_req;
  logic       change_pulse;
  logic       coin_reject;
  logic       sel_reject;
  logic       fault;
  logic [3:0] sold_out;

  function automatic logic [5:0] price_of(input logic [1:0] idx);
    case (idx)
      2'd0:    price_of = 6'(PRICE0);
      2'd1:    price_of = 6'(PRICE1);
      2'd2:    price_of = 6'(PRICE2);
      default: price_of = 6'(PRICE3);
    endcase
  endfunction

  logic [5:0] coin_val;
  logic       coin_valid;
  logic       coin_fits;
  logic       accepting;
  logic       cancel_ok;
  logic       sel_ok;
  logic       coin_ok;
  logic [5:0] sel_price;
  logic [5:0] cur_price;

  always_comb begin
    coin_val   = 6'd0;
    coin_valid = 1'b0;
    case (bus.x)
      2'b01:   begin coin_val = 6'd5;  coin_valid = 1'b1; end
      2'b10:   begin coin_val = 6'd10; coin_valid = 1'b1; end
      default: ;
    endcase
    sel_price = price_of(bus.sel);
    cur_price = price_of(disp_item);
    coin_fits = ({1'b0, credit} + {1'b0, coin_val}) <= MAX_L;
    accepting = (state == IDLE) || (state == COLLECT);
    cancel_ok = bus.cancel && (state == COLLECT);
    sel_ok    = bus.sel_valid && (stock[bus.sel] != 3'd0) && (credit >= sel_price);
    // Any purchase request or accepted cancel in the same cycle claims priority over the coin.
    coin_ok   = accepting && coin_valid && coin_fits && !cancel_ok && !bus.sel_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      credit       <= 6'd0;
      timer        <= 8'd0;
      disp_item    <= 2'd0;
      disp_req     <= 1'b0;
      change_pulse <= 1'b0;
      coin_reject  <= 1'b0;
      sel_reject   <= 1'b0;
      fault        <= 1'b0;
      sold_out     <= {4{STOCK_L == 3'd0}};
      for (int i = 0; i < 4; i++) stock[i] <= STOCK_L;
    end else begin
      coin_reject  <= (bus.x != 2'b00) && !coin_ok;
      sel_reject   <= 1'b0;
      fault        <= 1'b0;
      change_pulse <= 1'b0;
      case (state)
        IDLE, COLLECT: begin
          if (cancel_ok) begin
            state <= CHANGE;
          end else if (bus.sel_valid) begin
            if (sel_ok) begin
              credit    <= credit - sel_price;
              disp_item <= bus.sel;
              disp_req  <= 1'b1;
              timer     <= 8'd0;
              state     <= DISPENSE;
            end else begin
              sel_reject <= 1'b1;
            end
          end else if (coin_ok) begin
            credit <= credit + coin_val;
            state  <= COLLECT;
          end
          if ((state == IDLE) && bus.restock) begin
            for (int i = 0; i < 4; i++) stock[i] <= STOCK_L;
            sold_out <= {4{STOCK_L == 3'd0}};
          end
        end
        DISPENSE: begin
          if (bus.disp_ack) begin
            disp_req <= 1'b0;
            if (stock[disp_item] != 3'd0) stock[disp_item] <= stock[disp_item] - 3'd1;
            sold_out[disp_item] <= (stock[disp_item] <= 3'd1);
            state <= (credit != 6'd0) ? CHANGE : IDLE;
          end else if (timer == TO_LAST) begin
            // Failed dispense: refund the price into credit and pay it all back.
            disp_req <= 1'b0;
            fault    <= 1'b1;
            credit   <= credit + cur_price;
            state    <= CHANGE;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        default: begin
          if (credit != 6'd0) begin
            change_pulse <= 1'b1;
            credit       <= credit - 6'd5;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.disp_req     = disp_req;
  assign bus.disp_item    = disp_item;
  assign bus.change_pulse = change_pulse;
  assign bus.coin_reject  = coin_reject;
  assign bus.sel_reject   = sel_reject;
  assign bus.fault        = fault;
  assign bus.credit       = credit;
  assign bus.sold_out     = sold_out;
  assign bus.state_dbg    = state;

endmodule

// File: tb/tb_vending_controller.sv
// Directed bench for vending_controller with default parameters; expected values are hand-computed.
module tb_vending_controller;

  localparam logic [1:0] S_IDLE = 2'd0, S_COLLECT = 2'd1, S_DISPENSE = 2'd2, S_CHANGE = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  vending_if vif();

  vending_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (vif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic [1:0] code);
    vif.x = code;
    tick();
    vif.x = 2'b00;
  endtask

  task automatic buy(input logic [1:0] item);
    vif.sel = item;
    vif.sel_valid = 1'b1;
    tick();
    vif.sel_valid = 1'b0;
  endtask

  task automatic ack();
    vif.disp_ack = 1'b1;
    tick();
    vif.disp_ack = 1'b0;
  endtask

  task automatic do_cancel();
    vif.cancel = 1'b1;
    tick();
    vif.cancel = 1'b0;
  endtask

  // Runs until IDLE (bounded) and checks the number of change pulses seen.
  task automatic drain(input string tag, input int exp_pulses);
    int cnt;
    bit done;
    cnt = 0;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      if (vif.change_pulse) cnt++;
      if (vif.state_dbg == S_IDLE) done = 1;
    end
    check({tag, "_reached_idle"}, 32'(done), 32'd1);
    check({tag, "_pulses"}, 32'(cnt), 32'(exp_pulses));
    check({tag, "_credit"}, 32'(vif.credit), 32'd0);
  endtask

  initial begin
    vif.x = 2'b00; vif.sel = 2'd0; vif.sel_valid = 1'b0; vif.cancel = 1'b0;
    vif.restock = 1'b0; vif.disp_ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_state", 32'(vif.state_dbg), 32'(S_IDLE));
    check("rst_credit", 32'(vif.credit), 32'd0);
    check("rst_disp_req", 32'(vif.disp_req), 32'd0);
    check("rst_disp_item", 32'(vif.disp_item), 32'd0);
    check("rst_sold_out", 32'(vif.sold_out), 32'd0);
    check("rst_pulses", 32'({vif.change_pulse, vif.coin_reject, vif.sel_reject, vif.fault}), 32'd0);

    // Exact purchase of item 0
    coin(2'b01);
    check("ex_credit5", 32'(vif.credit), 32'd5);
    check("ex_collect", 32'(vif.state_dbg), 32'(S_COLLECT));
    coin(2'b10);
    check("ex_credit15", 32'(vif.credit), 32'd15);
    buy(2'd0);
    check("ex_disp_req", 32'(vif.disp_req), 32'd1);
    check("ex_disp_item", 32'(vif.disp_item), 32'd0);
    check("ex_credit0", 32'(vif.credit), 32'd0);
    check("ex_dispense", 32'(vif.state_dbg), 32'(S_DISPENSE));
    ack();
    check("ex_req_drop", 32'(vif.disp_req), 32'd0);
    check("ex_idle", 32'(vif.state_dbg), 32'(S_IDLE));
    tick();
    check("ex_no_change", 32'(vif.change_pulse), 32'd0);

    // Overpayment: 20 for a 15 item -> one change coin
    coin(2'b10); coin(2'b10);
    buy(2'd0);
    check("ov_credit5", 32'(vif.credit), 32'd5);
    ack();
    check("ov_change_state", 32'(vif.state_dbg), 32'(S_CHANGE));
    drain("ov", 1);

    // Refusals
    coin(2'b01); coin(2'b10);
    buy(2'd2);
    check("rf_sel_reject", 32'(vif.sel_reject), 32'd1);
    check("rf_credit15", 32'(vif.credit), 32'd15);
    check("rf_state", 32'(vif.state_dbg), 32'(S_COLLECT));
    tick();
    check("rf_sel_reject_clr", 32'(vif.sel_reject), 32'd0);
    coin(2'b10); coin(2'b01);
    check("rf_credit30", 32'(vif.credit), 32'd30);
    coin(2'b01);
    check("rf_over_max", 32'(vif.coin_reject), 32'd1);
    check("rf_credit_kept", 32'(vif.credit), 32'd30);
    coin(2'b11);
    check("rf_invalid", 32'(vif.coin_reject), 32'd1);
    do_cancel();
    drain("rf", 6);

    // Cancel, and cancel with a coin in the same cycle
    coin(2'b01);
    do_cancel();
    check("cn_change", 32'(vif.state_dbg), 32'(S_CHANGE));
    drain("cn1", 1);
    do_cancel();
    check("cn_idle_ignored", 32'(vif.state_dbg), 32'(S_IDLE));
    coin(2'b01);
    vif.x = 2'b01; vif.cancel = 1'b1;
    tick();
    vif.x = 2'b00; vif.cancel = 1'b0;
    check("cn_coin_reject", 32'(vif.coin_reject), 32'd1);
    check("cn_credit5", 32'(vif.credit), 32'd5);
    drain("cn2", 1);

    // Timeout with credit 20 buying item 0 (stock0 is 1 at this point)
    coin(2'b10); coin(2'b10);
    buy(2'd0);
    for (int i = 0; i < 7; i++) begin
      tick();
      check("to_req_held", 32'(vif.disp_req), 32'd1);
    end
    tick();
    check("to_fault", 32'(vif.fault), 32'd1);
    check("to_credit20", 32'(vif.credit), 32'd20);
    check("to_req_drop", 32'(vif.disp_req), 32'd0);
    drain("to", 4);
    check("to_fault_clr", 32'(vif.fault), 32'd0);
    coin(2'b10); coin(2'b01);
    buy(2'd0);
    check("to_stock_kept", 32'(vif.disp_req), 32'd1);
    ack();
    check("to_sold0", 32'(vif.sold_out), 32'b0001);

    // Ack outside DISPENSE is ignored
    ack();
    check("ack_ignored", 32'(vif.sold_out), 32'b0001);

    // Sell out item 3
    for (int i = 0; i < 3; i++) begin
      coin(2'b10);
      buy(2'd3);
      ack();
    end
    check("so_bits", 32'(vif.sold_out), 32'b1001);
    coin(2'b10);
    buy(2'd3);
    check("so_reject", 32'(vif.sel_reject), 32'd1);
    vif.restock = 1'b1;
    tick();
    vif.restock = 1'b0;
    check("so_restock_ignored", 32'(vif.sold_out), 32'b1001);
    do_cancel();
    drain("so", 2);
    vif.restock = 1'b1;
    tick();
    vif.restock = 1'b0;
    check("so_restocked", 32'(vif.sold_out), 32'b0000);

    // Ack arriving on the last allowed cycle counts as ack
    coin(2'b10);
    buy(2'd3);
    for (int i = 0; i < 7; i++) tick();
    ack();
    check("tie_no_fault", 32'(vif.fault), 32'd0);
    check("tie_idle", 32'(vif.state_dbg), 32'(S_IDLE));

    // Reset during CHANGE
    coin(2'b10); coin(2'b10);
    do_cancel();
    tick();
    check("rc_first_pulse", 32'(vif.change_pulse), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rc_credit", 32'(vif.credit), 32'd0);
    check("rc_state", 32'(vif.state_dbg), 32'(S_IDLE));
    check("rc_pulse", 32'(vif.change_pulse), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rc_no_pulse", 32'(vif.change_pulse), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
